// File: rtl/reg_file_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_pkg
// Shared types, default widths and the write-qualify helper for the multi-port
// register file (reg_file_mp) and its read-port sub-module (rf_read_port).
//
// Contents:
//   rf_state_t   - two-state controller encoding (CLEAR, IDLE)
//   RF_M, RF_N   - default data / address widths
//   rf_wr_legal  - decides whether a write request may touch the array
// -----------------------------------------------------------------------------
package reg_file_pkg;

  typedef enum logic {CLEAR, IDLE} rf_state_t;

  localparam int RF_M = 32;
  localparam int RF_N = 5;

  // A write is legal when it is enabled, lands inside the populated part of the
  // address space and does not target the hardwired zero entry. Addresses and
  // depth are carried as 32-bit values so the helper is independent of N.
  function automatic logic rf_wr_legal(input logic [31:0] addr,
                                       input logic        we,
                                       input logic        zero_reg,
                                       input logic [31:0] depth);
    return we && (addr < depth) && !(zero_reg && (addr == 32'd0));
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// -----------------------------------------------------------------------------
// reg_file_mp_if
// Bus bundle between the datapath (master) and the register file (slave).
//
// Parameters: M data width, N address width, NUM_RD number of read ports.
// Signals:
//   we0/wa0/wd0  write port 0 (enable, address, data)
//   we1/wa1/wd1  write port 1, wins over port 0 on an address collision
//   ra           packed read addresses, port k at [k*N +: N]
//   rd           packed read data, port k at [k*M +: M]
//   busy         high while the post-reset clear sequence runs
// -----------------------------------------------------------------------------
interface reg_file_mp_if
  import reg_file_pkg::*;
#(
  parameter int M      = RF_M,
  parameter int N      = RF_N,
  parameter int NUM_RD = 2
);

  logic                we0;
  logic [N-1:0]        wa0;
  logic [M-1:0]        wd0;
  logic                we1;
  logic [N-1:0]        wa1;
  logic [M-1:0]        wd1;
  logic [NUM_RD*N-1:0] ra;
  logic [NUM_RD*M-1:0] rd;
  logic                busy;

  modport master (
    output we0, wa0, wd0,
    output we1, wa1, wd1,
    output ra,
    input  rd, busy
  );

  modport slave (
    input  we0, wa0, wd0,
    input  we1, wa1, wd1,
    input  ra,
    output rd, busy
  );

endinterface

// File: rtl/rf_read_port.sv
// -----------------------------------------------------------------------------
// rf_read_port
// One combinational read port of reg_file_mp. Applies, in order:
//   - busy (clear running)      -> 0
//   - address >= DEPTH          -> 0
//   - address 0 with ZERO_REG   -> 0
//   - otherwise the stored entry, optionally overridden by a same-cycle write
//
// Optional feature: macro REGFILE_BYPASS_EN adds the write-to-read bypass
// ports and muxing; without it the port returns the stored value only.
//
// Ports:
//   busy           in   clear sequence running
//   ra             in   N-bit read address
//   mem            in   the storage array (DEPTH x M)
//   wr0_ok/wa0/wd0 in   qualified write port 0   (bypass build only)
//   wr1_ok/wa1/wd1 in   qualified write port 1   (bypass build only)
//   rd             out  M-bit read data
// -----------------------------------------------------------------------------
module rf_read_port
  import reg_file_pkg::*;
#(
  parameter int M        = RF_M,
  parameter int N        = RF_N,
  parameter int DEPTH    = 2**N,
  parameter int ZERO_REG = 1
) (
  input  logic         busy,
  input  logic [N-1:0] ra,
  input  logic [M-1:0] mem [DEPTH],
`ifdef REGFILE_BYPASS_EN
  input  logic         wr0_ok,
  input  logic [N-1:0] wa0,
  input  logic [M-1:0] wd0,
  input  logic         wr1_ok,
  input  logic [N-1:0] wa1,
  input  logic [M-1:0] wd1,
`endif
  output logic [M-1:0] rd
);

  logic in_range;
  logic zero_hit;

  assign in_range = 32'(ra) < 32'(DEPTH);
  assign zero_hit = (ZERO_REG != 0) && (ra == '0);

  // NOTE: rd gets a default before any branch so this block can never infer a
  // latch, whatever combination of conditions is false.
  always_comb begin
    rd = '0;
    if (!busy && in_range && !zero_hit) begin
      rd = mem[ra];
`ifdef REGFILE_BYPASS_EN
      // Port 1 is tested last so it overrides port 0, mirroring write priority.
      // wrX_ok already excludes zero and out-of-range targets.
      if (wr0_ok && (wa0 == ra)) rd = wd0;
      if (wr1_ok && (wa1 == ra)) rd = wd1;
`endif
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// -----------------------------------------------------------------------------
// reg_file_mp
// Parametrised register file: NUM_RD combinational read ports, two synchronous
// write ports (port 1 wins on a same-address collision), optional hardwired
// zero entry, and a post-reset clear sequencer that zeroes one entry per cycle
// while holding busy high.
//
// Parameters: M data width, N address width, DEPTH entries (2..2**N),
//             NUM_RD read ports (1..4), ZERO_REG (1 = entry 0 reads 0).
// Optional feature: macro REGFILE_BYPASS_EN enables same-cycle write-to-read
//                   bypass in every read port.
//
// Ports:
//   clk  in   rising-edge clock
//   rst  in   synchronous, active-high reset
//   bus  slave modport of reg_file_mp_if (write ports, read ports, busy)
// -----------------------------------------------------------------------------
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int M        = RF_M,
  parameter int N        = RF_N,
  parameter int DEPTH    = 2**N,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          rst,
  reg_file_mp_if.slave  bus
);

  // clr_cnt is one bit wider than the address so DEPTH == 2**N ends cleanly.
  localparam logic [N:0] LAST_IDX = (N+1)'(DEPTH - 1);

  rf_state_t     state;
  logic [N:0]    clr_cnt;
  logic [M-1:0]  mem [DEPTH];
  logic          busy;
  logic          wr0_ok;
  logic          wr1_ok;

  assign busy     = (state == CLEAR);
  assign bus.busy = busy;

  assign wr0_ok = rf_wr_legal(32'(bus.wa0), bus.we0, ZERO_REG != 0, 32'(DEPTH));
  assign wr1_ok = rf_wr_legal(32'(bus.wa1), bus.we1, ZERO_REG != 0, 32'(DEPTH));

  // Clear controller. Reset always restarts the sweep from entry 0.
  // NOTE: all sequential state is assigned with <= so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST_IDX) state <= IDLE;
        end
        IDLE:    state <= IDLE;
        default: state <= CLEAR;
      endcase
    end
  end

  // Storage. NOTE: the array has no reset branch; the clear sequencer zeroes it
  // one entry per cycle instead, which keeps it mappable to plain RAM/flops
  // without a wide reset fan-out.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[clr_cnt[N-1:0]] <= '0;
      end else begin
        // Port 1 is written second, so on a collision its value is the one kept.
        if (wr0_ok) mem[bus.wa0] <= bus.wd0;
        if (wr1_ok) mem[bus.wa1] <= bus.wd1;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    rf_read_port #(
      .M        (M),
      .N        (N),
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG)
    ) u_rd (
      .busy   (busy),
      .ra     (bus.ra[k*N +: N]),
      .mem    (mem),
`ifdef REGFILE_BYPASS_EN
      .wr0_ok (wr0_ok),
      .wa0    (bus.wa0),
      .wd0    (bus.wd0),
      .wr1_ok (wr1_ok),
      .wa1    (bus.wa1),
      .wd1    (bus.wd1),
`endif
      .rd     (bus.rd[k*M +: M])
    );
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// -----------------------------------------------------------------------------
// tb_reg_file_mp
// Drives two reg_file_mp instances in lockstep from shared write stimulus:
//   dut_a : DEPTH=32, NUM_RD=2  (default geometry)
//   dut_b : DEPTH=24, NUM_RD=4  (partial depth, four read ports)
// A behavioural model (plain arrays plus a remaining-clear-cycles count) gives
// the expected busy and read data every cycle. Honours REGFILE_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_reg_file_mp;

  localparam int DEPTH_A = 32;
  localparam int DEPTH_B = 24;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  reg_file_mp_if #(.M(32), .N(5), .NUM_RD(2)) bus_a ();
  reg_file_mp_if #(.M(32), .N(5), .NUM_RD(4)) bus_b ();

  reg_file_mp #(.M(32), .N(5), .DEPTH(DEPTH_A), .NUM_RD(2), .ZERO_REG(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  reg_file_mp #(.M(32), .N(5), .DEPTH(DEPTH_B), .NUM_RD(4), .ZERO_REG(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  // Stimulus shared by both instances (read addresses are per instance).
  logic        we0, we1;
  logic [4:0]  wa0, wa1;
  logic [31:0] wd0, wd1;
  logic [4:0]  ra_a [2];
  logic [4:0]  ra_b [4];

  // Reference model state.
  logic [31:0] mem_a [DEPTH_A];
  logic [31:0] mem_b [DEPTH_B];
  int          left_a;
  int          left_b;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic bit legal(input int addr, input int depth, input bit en);
    return en && (addr < depth) && (addr != 0);
  endfunction

  function automatic logic [31:0] ref_read(input bit is_b, input int addr);
    int depth;
    depth = is_b ? DEPTH_B : DEPTH_A;
    if ((is_b ? left_b : left_a) > 0) return 32'h0;
    if (addr >= depth || addr == 0)   return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (we1 && int'(wa1) == addr) return wd1;
    if (we0 && int'(wa0) == addr) return wd0;
`endif
    return is_b ? mem_b[addr] : mem_a[addr];
  endfunction

  task automatic model_edge();
    if (rst) begin
      foreach (mem_a[i]) mem_a[i] = 32'h0;
      foreach (mem_b[i]) mem_b[i] = 32'h0;
      left_a = DEPTH_A;
      left_b = DEPTH_B;
    end else begin
      if (left_a > 0) left_a--;
      else begin
        if (legal(int'(wa0), DEPTH_A, we0)) mem_a[wa0] = wd0;
        if (legal(int'(wa1), DEPTH_A, we1)) mem_a[wa1] = wd1;
      end
      if (left_b > 0) left_b--;
      else begin
        if (legal(int'(wa0), DEPTH_B, we0)) mem_b[wa0] = wd0;
        if (legal(int'(wa1), DEPTH_B, we1)) mem_b[wa1] = wd1;
      end
    end
  endtask

  task automatic drive();
    bus_a.we0 = we0; bus_a.wa0 = wa0; bus_a.wd0 = wd0;
    bus_a.we1 = we1; bus_a.wa1 = wa1; bus_a.wd1 = wd1;
    bus_b.we0 = we0; bus_b.wa0 = wa0; bus_b.wd0 = wd0;
    bus_b.we1 = we1; bus_b.wa1 = wa1; bus_b.wd1 = wd1;
    for (int k = 0; k < 2; k++) bus_a.ra[k*5 +: 5] = ra_a[k];
    for (int k = 0; k < 4; k++) bus_b.ra[k*5 +: 5] = ra_b[k];
  endtask

  // Apply inputs at the falling edge, then compare every output 1 ns later.
  task automatic drive_cmp();
    drive();
    #1;
    check("busy_a", 32'(bus_a.busy), 32'(left_a > 0));
    check("busy_b", 32'(bus_b.busy), 32'(left_b > 0));
    for (int k = 0; k < 2; k++)
      check($sformatf("rd_a%0d_addr%0d", k, ra_a[k]), bus_a.rd[k*32 +: 32], ref_read(1'b0, int'(ra_a[k])));
    for (int k = 0; k < 4; k++)
      check($sformatf("rd_b%0d_addr%0d", k, ra_b[k]), bus_b.rd[k*32 +: 32], ref_read(1'b1, int'(ra_b[k])));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic cycle();
    drive_cmp();
    tick();
  endtask

  task automatic idle_inputs();
    we0 = 1'b0; we1 = 1'b0;
    wa0 = '0;   wa1 = '0;
    wd0 = '0;   wd1 = '0;
  endtask

  // Count busy cycles from rst deassertion until both instances are idle.
  // A write to address 3 is held on the bus the whole time and must be ignored.
  task automatic measure_clear(output int ca, output int cb);
    ca = 0;
    cb = 0;
    rst = 1'b0;
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hCAFE_0003;
    for (int i = 0; i < 100; i++) begin
      drive_cmp();
      if (bus_a.busy) ca++;
      if (bus_b.busy) cb++;
      if (!bus_a.busy && !bus_b.busy) break;
      tick();
    end
    idle_inputs();
  endtask

  int ca, cb;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    foreach (ra_a[k]) ra_a[k] = '0;
    foreach (ra_b[k]) ra_b[k] = '0;
    left_a = DEPTH_A;
    left_b = DEPTH_B;
    rst = 1'b1;
    drive();
    tick();              // first edge establishes state; no check before it
    cycle();
    cycle();             // rst held for three edges in total

    measure_clear(ca, cb);
    check("clear_len_a", 32'(ca), 32'd32);
    check("clear_len_b", 32'(cb), 32'd24);

    // Every entry reads zero after the clear; address 3 ignored the busy write.
    for (int i = 0; i < 32; i++) begin
      ra_a[0] = 5'(i); ra_a[1] = 5'(31 - i);
      for (int k = 0; k < 4; k++) ra_b[k] = 5'(i);
      drive_cmp();
      check("clear_zero_a", bus_a.rd[31:0], 32'h0);
      tick();
    end
    ra_a[0] = 5'd3;
    drive_cmp();
    check("busy_write_dropped", bus_a.rd[31:0], 32'h0);
    tick();

    // Reset reasserted mid-clear restarts the full sequence.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    rst = 1'b1;
    cycle();
    measure_clear(ca, cb);
    check("reclear_len_a", 32'(ca), 32'd32);
    check("reclear_len_b", 32'(cb), 32'd24);

    // Basic write then read.
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEAD_BEEF;
    ra_a[0] = 5'd5; ra_a[1] = 5'd6;
    cycle();
    idle_inputs();
    drive_cmp();
    check("wr5_rd", bus_a.rd[31:0],  32'hDEAD_BEEF);
    check("rd6",    bus_a.rd[63:32], 32'h0);
    tick();

    // Same-address collision: port 1 wins.
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h1111_1111;
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h2222_2222;
    ra_a[0] = 5'd7;
    cycle();
    idle_inputs();
    drive_cmp();
    check("collision7", bus_a.rd[31:0], 32'h2222_2222);
    tick();

    // Different addresses both commit.
    we0 = 1'b1; wa0 = 5'd8; wd0 = 32'h8888_8888;
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h9999_9999;
    ra_a[0] = 5'd8; ra_a[1] = 5'd9;
    cycle();
    idle_inputs();
    drive_cmp();
    check("dual8", bus_a.rd[31:0],  32'h8888_8888);
    check("dual9", bus_a.rd[63:32], 32'h9999_9999);
    tick();

    // Zero register ignores writes.
    we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFF_FFFF;
    ra_a[0] = 5'd0;
    cycle();
    idle_inputs();
    drive_cmp();
    check("zero_reg", bus_a.rd[31:0], 32'h0);
    tick();

    // Same-cycle read of the write address (entry 4 still holds 0).
    we0 = 1'b1; wa0 = 5'd4; wd0 = 32'hA5A5_A5A5;
    ra_a[0] = 5'd4;
    drive_cmp();
`ifdef REGFILE_BYPASS_EN
    check("bypass_same", bus_a.rd[31:0], 32'hA5A5_A5A5);
`else
    check("nobypass_same", bus_a.rd[31:0], 32'h0);
`endif
    tick();
    idle_inputs();
    drive_cmp();
    check("bypass_next", bus_a.rd[31:0], 32'hA5A5_A5A5);
    tick();

    // Out-of-range write on the 24-entry instance is dropped.
    we0 = 1'b1; wa0 = 5'd30; wd0 = 32'h1234_5678;
    for (int k = 0; k < 4; k++) ra_b[k] = 5'd30;
    cycle();
    idle_inputs();
    drive_cmp();
    for (int k = 0; k < 4; k++)
      check($sformatf("oor30_b%0d", k), bus_b.rd[k*32 +: 32], 32'h0);
    tick();

    // Randomised traffic against the model, with occasional resets.
    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      we0 = 1'($urandom); we1 = 1'($urandom);
      wa0 = 5'($urandom); wa1 = ($urandom_range(0, 3) == 0) ? wa0 : 5'($urandom);
      wd0 = $urandom;     wd1 = $urandom;
      for (int k = 0; k < 2; k++)
        ra_a[k] = ($urandom_range(0, 2) == 0) ? wa0 : 5'($urandom);
      for (int k = 0; k < 4; k++)
        ra_b[k] = ($urandom_range(0, 2) == 0) ? wa1 : 5'($urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
